// File: rtl/conv_encoder_r4_pkg.sv
// Shared trellis constants for the radix-4 convolutional encoder and its Viterbi decoder.
// The FSM enum is also reused by the decoder controller.
package conv_encoder_r4_pkg;

    localparam int STATE_W  = 8;
    localparam int SYM_W    = 2;
    localparam int RADIX    = 1 << SYM_W;
    localparam int CW_W     = 4;
    localparam int LEN_W    = 9;
    localparam int TAIL_SYM = STATE_W / SYM_W;
    localparam int WIN_W    = STATE_W + SYM_W;

    // Entry k produces cw[k]; entry 0 sits in the low bits.
    localparam logic [CW_W-1:0][WIN_W-1:0] GEN = {
        10'b0101010111,
        10'b1010101011,
        10'b0000000010,
        10'b0000000001
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_fsm_e;

    typedef struct packed {
        logic            vld;
        logic            last;
        logic [CW_W-1:0] cw;
    } cw_slot_t;

endpackage

// File: rtl/conv_encoder_r4_cw_gen.sv
// Combinational trellis step: (cur_st, sym) -> (nxt_st, cw). Shared with the decoder's
// branch-metric unit so the trellis is defined in one place.
module conv_cw_gen
    import conv_encoder_r4_pkg::*;
(
    input  logic [STATE_W-1:0] cur_st,
    input  logic [SYM_W-1:0]   sym,
    output logic [STATE_W-1:0] nxt_st,
    output logic [CW_W-1:0]    cw
);

    logic [SYM_W-1:0] sym_rev;
    logic [WIN_W-1:0] win;

    // Symbol bits enter the state reversed to match the decoder's {i[0],i[1]} indexing.
    for (genvar i = 0; i < SYM_W; i++) begin : g_rev
        assign sym_rev[i] = sym[SYM_W-1-i];
    end

    assign nxt_st = {cur_st[STATE_W-SYM_W-1:0], sym_rev};
    assign win    = {cur_st[STATE_W-1 -: SYM_W], nxt_st};

    for (genvar k = 0; k < CW_W; k++) begin : g_cw
        assign cw[k] = ^(win & GEN[k]);
    end

endmodule

// File: rtl/conv_encoder_r4.sv
// Frame-based radix-4 convolutional encoder: data symbols followed by TAIL_SYM zero
// symbols so the trellis ends in state 0. Single registered output slot with pass-through.
module conv_encoder_r4
    import conv_encoder_r4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_enc,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [SYM_W-1:0] i_sym,
    input  logic             i_sym_valid,
    output logic             o_sym_ready,
    output logic [CW_W-1:0]  o_cw,
    output logic             o_cw_valid,
    input  logic             i_cw_ready,
    output logic             o_last,
    output logic             o_busy
);

    enc_fsm_e           fsm_q, fsm_d;
    logic [STATE_W-1:0] st_q, st_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    cw_slot_t           slot_q, slot_d;

    logic               slot_free;
    logic               sym_acc;
    logic [SYM_W-1:0]   gen_sym;
    logic [STATE_W-1:0] gen_nxt;
    logic [CW_W-1:0]    gen_cw;

    assign slot_free   = !slot_q.vld || i_cw_ready;
    assign o_sym_ready = (fsm_q == DATA) && en_enc && slot_free;
    assign sym_acc     = o_sym_ready && i_sym_valid;
    assign gen_sym     = (fsm_q == DATA) ? i_sym : '0;

    conv_cw_gen u_cw_gen (
        .cur_st (st_q),
        .sym    (gen_sym),
        .nxt_st (gen_nxt),
        .cw     (gen_cw)
    );

    always_comb begin
        fsm_d       = fsm_q;
        st_d        = st_q;
        cnt_d       = cnt_q;
        slot_d      = slot_q;
        // A downstream handshake drains the slot even while en_enc is low.
        slot_d.vld  = slot_q.vld && !i_cw_ready;
        slot_d.last = slot_q.last && !i_cw_ready;
        case (fsm_q)
            IDLE: begin
                if (en_enc && i_start) begin
                    if (i_len != '0) begin
                        fsm_d = DATA;
                        cnt_d = i_len;
                    end else begin
                        fsm_d = TAIL;
                        cnt_d = LEN_W'(TAIL_SYM);
                    end
                end
            end
            DATA: begin
                if (sym_acc) begin
                    st_d        = gen_nxt;
                    slot_d.cw   = gen_cw;
                    slot_d.vld  = 1'b1;
                    slot_d.last = 1'b0;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        fsm_d = TAIL;
                        cnt_d = LEN_W'(TAIL_SYM);
                    end
                end
            end
            TAIL: begin
                if (en_enc && slot_free) begin
                    st_d        = gen_nxt;
                    slot_d.cw   = gen_cw;
                    slot_d.vld  = 1'b1;
                    slot_d.last = (cnt_q == LEN_W'(1));
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q  <= IDLE;
            st_q   <= '0;
            cnt_q  <= '0;
            slot_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
        end
    end

    assign o_cw       = slot_q.cw;
    assign o_cw_valid = slot_q.vld;
    assign o_last     = slot_q.last;
    assign o_busy     = (fsm_q != IDLE);

endmodule
